// File: rtl/decoder_n_seq.sv
// Registered N-to-2**N one-hot decoder with enable.
// DIRECT registers the decode of In; SCAN walks the one-hot bit across every index.
module decoder_n_seq #(
  parameter int N         = 3,
  parameter int STEP      = 1,
  parameter int WRAP_STOP = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              E,
  input  logic              mode,
  input  logic              load,
  input  logic [N-1:0]      In,
  output logic [2**N-1:0]   Out,
  output logic [N-1:0]      idx,
  output logic              out_valid,
  output logic              wrap
);

  localparam int W  = 2**N;
  localparam int CW = (STEP > 1) ? $clog2(STEP) : 1;
  localparam logic [N-1:0]  LAST     = '1;
  localparam logic [CW-1:0] STEP_END = CW'(STEP - 1);
  localparam logic [W-1:0]  ONE      = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_DIRECT, S_SCAN, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_idx, w_idx_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [W-1:0]  r_out, w_out_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_wrap, w_wrap_nxt;

  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave it unassigned and infer a latch.
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_valid;
    w_wrap_nxt  = 1'b0;

    if (!E) begin
      w_state_nxt = S_IDLE;
      w_valid_nxt = 1'b0;
      w_cnt_nxt   = '0;
    end else if (!mode) begin
      w_state_nxt = S_DIRECT;
      w_idx_nxt   = In;
      w_valid_nxt = 1'b1;
    end else if (load || (r_state != S_SCAN && r_state != S_DONE)) begin
      // Fresh SCAN entry (from IDLE/DIRECT) or restart; beats any pending advance.
      w_state_nxt = S_SCAN;
      w_idx_nxt   = In;
      w_cnt_nxt   = '0;
      w_valid_nxt = 1'b1;
    end else if (r_state == S_SCAN) begin
      if (r_cnt == STEP_END) begin
        w_cnt_nxt = '0;
        if (r_idx == LAST) begin
          w_wrap_nxt = 1'b1;
          if (WRAP_STOP != 0) w_state_nxt = S_DONE;
          else                w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end

    // Out is rebuilt from the next index so it can never disagree with idx.
    w_out_nxt = w_valid_nxt ? (ONE << w_idx_nxt) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_valid <= w_valid_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign Out       = r_out;
  assign idx       = r_idx;
  assign out_valid = r_valid;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_decoder_n_seq.sv
// Bench for decoder_n_seq: directed vector tables at N=3, then randomised
// traffic at N=1 and N=5 checked against a behavioural model through a scoreboard.
module tb_decoder_n_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, e, mode, load;
  logic [2:0] in3;
  logic [0:0] in1;
  logic [4:0] in5;

  logic [7:0]  out_a, out_b;
  logic [2:0]  idx_a, idx_b;
  logic [1:0]  out_c;
  logic [0:0]  idx_c;
  logic [31:0] out_d;
  logic [4:0]  idx_d;
  logic        val_a, val_b, val_c, val_d;
  logic        wrp_a, wrp_b, wrp_c, wrp_d;

  decoder_n_seq #(.N(3), .STEP(2), .WRAP_STOP(0)) u_a (
    .clk(clk), .rst(rst), .E(e), .mode(mode), .load(load), .In(in3),
    .Out(out_a), .idx(idx_a), .out_valid(val_a), .wrap(wrp_a));
  decoder_n_seq #(.N(3), .STEP(1), .WRAP_STOP(1)) u_b (
    .clk(clk), .rst(rst), .E(e), .mode(mode), .load(load), .In(in3),
    .Out(out_b), .idx(idx_b), .out_valid(val_b), .wrap(wrp_b));
  decoder_n_seq #(.N(1), .STEP(2), .WRAP_STOP(0)) u_c (
    .clk(clk), .rst(rst), .E(e), .mode(mode), .load(load), .In(in1),
    .Out(out_c), .idx(idx_c), .out_valid(val_c), .wrap(wrp_c));
  decoder_n_seq #(.N(5), .STEP(3), .WRAP_STOP(1)) u_d (
    .clk(clk), .rst(rst), .E(e), .mode(mode), .load(load), .In(in5),
    .Out(out_d), .idx(idx_d), .out_valid(val_d), .wrap(wrp_d));

  typedef struct {
    bit         rst, e, mode, load;
    logic [2:0] in;
    logic [7:0] out;
    logic [2:0] idx;
    bit         valid, wrap;
  } vec_t;

  typedef struct {
    string       tag;
    int          inst;
    logic [31:0] out;
    int          idx;
    bit          valid, wrap;
  } exp_t;

  // Model states: 0 IDLE, 1 DIRECT, 2 SCAN, 3 DONE.
  typedef struct {
    int st, idx, cnt;
    bit valid, wrap;
  } mstate_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  function automatic void add(input bit r, input bit en, input bit m, input bit l,
                              input logic [2:0] in, input logic [7:0] out,
                              input logic [2:0] ix, input bit v, input bit w);
    vec_t t;
    t.rst = r; t.e = en; t.mode = m; t.load = l; t.in = in;
    t.out = out; t.idx = ix; t.valid = v; t.wrap = w;
    vecs.push_back(t);
  endfunction

  // Advance one clock, then compare every expectation queued for this edge.
  task automatic step_and_check();
    exp_t        x;
    logic [31:0] a_out;
    int          a_idx;
    bit          a_v, a_w;
    @(posedge clk);
    #1;
    while (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      case (x.inst)
        0:       begin a_out = 32'(out_a); a_idx = int'(idx_a); a_v = val_a; a_w = wrp_a; end
        1:       begin a_out = 32'(out_b); a_idx = int'(idx_b); a_v = val_b; a_w = wrp_b; end
        2:       begin a_out = 32'(out_c); a_idx = int'(idx_c); a_v = val_c; a_w = wrp_c; end
        default: begin a_out = out_d;      a_idx = int'(idx_d); a_v = val_d; a_w = wrp_d; end
      endcase
      check({x.tag, ".out"},   a_out,       x.out);
      check({x.tag, ".idx"},   32'(a_idx),  32'(x.idx));
      check({x.tag, ".valid"}, 32'(a_v),    32'(x.valid));
      check({x.tag, ".wrap"},  32'(a_w),    32'(x.wrap));
    end
  endtask

  task automatic run_vecs(input string tag, input int inst);
    exp_t x;
    foreach (vecs[i]) begin
      rst = vecs[i].rst; e = vecs[i].e; mode = vecs[i].mode;
      load = vecs[i].load; in3 = vecs[i].in;
      x.tag   = $sformatf("%s[%0d]", tag, i);
      x.inst  = inst;
      x.out   = 32'(vecs[i].out);
      x.idx   = int'(vecs[i].idx);
      x.valid = vecs[i].valid;
      x.wrap  = vecs[i].wrap;
      exp_q.push_back(x);
      step_and_check();
    end
    vecs.delete();
  endtask

  function automatic mstate_t model(input mstate_t s, input bit r, input bit en, input bit m,
                                    input bit ld, input int in, input int n,
                                    input int step, input bit ws);
    mstate_t t = s;
    t.wrap = 1'b0;
    if (r) begin
      t.st = 0; t.idx = 0; t.cnt = 0; t.valid = 1'b0;
    end else if (!en) begin
      t.st = 0; t.cnt = 0; t.valid = 1'b0;
    end else if (!m) begin
      t.st = 1; t.idx = in; t.valid = 1'b1;
    end else if (ld || s.st < 2) begin
      t.st = 2; t.idx = in; t.cnt = 0; t.valid = 1'b1;
    end else if (s.st == 2) begin
      if (s.cnt + 1 < step) begin
        t.cnt = s.cnt + 1;
      end else begin
        t.cnt = 0;
        if (s.idx + 1 < (1 << n)) t.idx = s.idx + 1;
        else begin
          t.wrap = 1'b1;
          if (ws) t.st = 3;
          else    t.idx = 0;
        end
      end
    end
    return t;
  endfunction

  function automatic exp_t model_exp(input string tag, input int inst, input mstate_t s);
    exp_t x;
    x.tag   = tag;
    x.inst  = inst;
    x.out   = s.valid ? (32'd1 << s.idx) : 32'd0;
    x.idx   = s.idx;
    x.valid = s.valid;
    x.wrap  = s.wrap;
    return x;
  endfunction

  initial begin
    mstate_t mc, md;
    rst = 1'b1; e = 1'b0; mode = 1'b0; load = 1'b0;
    in3 = '0; in1 = '0; in5 = '0;

    // Reset with every input active.
    add(1,1,1,1, 3'd5, 8'h00, 3'd0, 0, 0);
    add(1,1,1,1, 3'd5, 8'h00, 3'd0, 0, 0);
    run_vecs("reset", 0);

    // DIRECT, E=0 hold of idx, SCAN walk with STEP=2 and wrap, load/advance collision,
    // mode change re-entry, reset mid-SCAN.
    add(0,1,0,0, 3'd5, 8'h20, 3'd5, 1, 0);
    add(0,1,0,0, 3'd0, 8'h01, 3'd0, 1, 0);
    add(0,1,0,1, 3'd3, 8'h08, 3'd3, 1, 0);
    add(0,0,0,0, 3'd2, 8'h00, 3'd3, 0, 0);
    add(0,1,1,0, 3'd6, 8'h40, 3'd6, 1, 0);
    add(0,1,1,0, 3'd0, 8'h40, 3'd6, 1, 0);
    add(0,1,1,0, 3'd0, 8'h80, 3'd7, 1, 0);
    add(0,1,1,0, 3'd0, 8'h80, 3'd7, 1, 0);
    add(0,1,1,0, 3'd0, 8'h01, 3'd0, 1, 1);
    add(0,1,1,0, 3'd0, 8'h01, 3'd0, 1, 0);
    add(0,1,1,0, 3'd0, 8'h02, 3'd1, 1, 0);
    add(0,1,1,1, 3'd7, 8'h80, 3'd7, 1, 0);
    add(0,1,1,0, 3'd0, 8'h80, 3'd7, 1, 0);
    add(0,1,1,1, 3'd3, 8'h08, 3'd3, 1, 0);
    add(0,1,1,0, 3'd0, 8'h08, 3'd3, 1, 0);
    add(0,1,1,0, 3'd0, 8'h10, 3'd4, 1, 0);
    add(0,1,0,0, 3'd1, 8'h02, 3'd1, 1, 0);
    add(0,1,1,0, 3'd5, 8'h20, 3'd5, 1, 0);
    add(0,1,1,0, 3'd0, 8'h20, 3'd5, 1, 0);
    add(1,1,1,0, 3'd0, 8'h00, 3'd0, 0, 0);
    add(0,1,1,0, 3'd4, 8'h10, 3'd4, 1, 0);
    run_vecs("scan_wrap", 0);

    // WRAP_STOP=1, STEP=1: stop on last index, DONE hold, load resume, start at last index.
    add(1,0,0,0, 3'd0, 8'h00, 3'd0, 0, 0);
    add(0,1,1,0, 3'd6, 8'h40, 3'd6, 1, 0);
    add(0,1,1,0, 3'd0, 8'h80, 3'd7, 1, 0);
    add(0,1,1,0, 3'd0, 8'h80, 3'd7, 1, 1);
    add(0,1,1,0, 3'd0, 8'h80, 3'd7, 1, 0);
    add(0,1,1,0, 3'd0, 8'h80, 3'd7, 1, 0);
    add(0,1,1,1, 3'd2, 8'h04, 3'd2, 1, 0);
    add(0,1,1,0, 3'd0, 8'h08, 3'd3, 1, 0);
    add(0,1,1,1, 3'd7, 8'h80, 3'd7, 1, 0);
    add(0,1,1,0, 3'd0, 8'h80, 3'd7, 1, 1);
    add(0,1,1,0, 3'd0, 8'h80, 3'd7, 1, 0);
    add(0,1,0,0, 3'd1, 8'h02, 3'd1, 1, 0);
    add(0,1,1,0, 3'd7, 8'h80, 3'd7, 1, 0);
    add(0,1,1,0, 3'd0, 8'h80, 3'd7, 1, 1);
    add(0,0,1,0, 3'd0, 8'h00, 3'd7, 0, 0);
    add(0,1,1,0, 3'd5, 8'h20, 3'd5, 1, 0);
    run_vecs("scan_stop", 1);

    // Random traffic at N=1 and N=5; first cycle resets so the model starts in step.
    mc = '{default: 0};
    md = '{default: 0};
    for (int k = 0; k < 400; k++) begin
      rst  = (k == 0) || ($urandom_range(63) == 0);
      e    = ($urandom_range(7) != 0);
      if ($urandom_range(15) == 0) mode = ~mode;
      load = ($urandom_range(7) == 0);
      in1  = 1'($urandom_range(1));
      in3  = 3'($urandom_range(7));
      in5  = 5'($urandom_range(31));
      mc = model(mc, rst, e, mode, load, int'(in1), 1, 2, 1'b0);
      md = model(md, rst, e, mode, load, int'(in5), 5, 3, 1'b1);
      exp_q.push_back(model_exp($sformatf("rnd%0d.n1", k), 2, mc));
      exp_q.push_back(model_exp($sformatf("rnd%0d.n5", k), 3, md));
      step_and_check();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
